// File: rtl/mem_pkg.sv
// Shared memory-side definitions: byte-enable encodings, the store-buffer
// entry layout and the default buffer depth.
package mem_pkg;

  localparam int SB_DEPTH = 4;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_BYTE1   = 4'b0010;
  localparam logic [3:0] BE_BYTE2   = 4'b0100;
  localparam logic [3:0] BE_BYTE3   = 4'b1000;
  localparam logic [3:0] BE_NONE    = 4'b0000;

  typedef struct packed {
    logic [29:0] addr_hi;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] pc;
  } sb_entry_t;

endpackage

// File: rtl/dm_store_buffer_if.sv
// Pipeline <-> store buffer <-> DM write port signal bundle.
interface dm_store_buffer_if;
  // A store transfers on a rising edge where st_valid && st_ready; st_ready
  // never depends on st_valid, and st_valid must hold until it is taken.
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic [31:0] st_pc;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [3:0]  fwd_mask;
  logic [31:0] fwd_data;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_pc;
  logic        empty;

  modport slave (
    input  st_valid, st_addr, st_data, st_be, st_pc, ld_valid, ld_addr,
    output st_ready, fwd_mask, fwd_data, dm_we, dm_addr, dm_wdata, dm_be,
           dm_pc, empty
  );

  modport master (
    output st_valid, st_addr, st_data, st_be, st_pc, ld_valid, ld_addr,
    input  st_ready, fwd_mask, fwd_data, dm_we, dm_addr, dm_wdata, dm_be,
           dm_pc, empty
  );
endinterface

// File: rtl/sb_fwd_merge.sv
// Per-lane load forwarding from pending stores; the youngest matching entry
// with a lane enabled supplies that byte.
module sb_fwd_merge
  import mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t        entries [DEPTH],
    input  logic [DEPTH-1:0] valid,
    input  logic [PTR_W-1:0] head,
    input  logic [PTR_W:0]   count,
    input  logic             ld_valid,
    input  logic [29:0]      ld_addr_hi,
    output logic [3:0]       fwd_mask,
    output logic [31:0]      fwd_data
);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so a later (younger) match overwrites a lane.
    always_comb begin
        fwd_mask = '0;
        fwd_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (ld_valid && ((PTR_W+1)'(k) < count) && valid[idx] &&
                (entries[idx].addr_hi == ld_addr_hi)) begin
                for (int b = 0; b < 4; b++) begin
                    if (entries[idx].be[b]) begin
                        fwd_mask[b]        = 1'b1;
                        fwd_data[8*b +: 8] = entries[idx].data[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/dm_store_buffer.sv
// Posted-write buffer in front of the data memory: in-order FIFO of stores,
// drained into DM whenever no load claims the port, with load forwarding.
module dm_store_buffer
  import mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    dm_store_buffer_if.slave   bus
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    sb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic [DEPTH-1:0] valid;
    logic             full;
    logic             is_empty;
    logic             enq;
    logic             drain;
    logic [3:0]       unused_addr_bits;

    assign unused_addr_bits = {bus.st_addr[1:0], bus.ld_addr[1:0]};

    assign full     = (count == FULL_CNT);
    assign is_empty = (count == '0);

    // Zero byte-enable stores are acknowledged but never occupy a slot.
    assign enq   = bus.st_valid && !full && (bus.st_be != BE_NONE);
    assign drain = !is_empty && !bus.ld_valid;

    assign bus.st_ready = !full;
    assign bus.empty    = is_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq)   tail <= tail + 1'b1;
            if (drain) head <= head + 1'b1;
            case ({enq, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            entries[tail] <= '{addr_hi: bus.st_addr[31:2],
                               data:    bus.st_data,
                               be:      bus.st_be,
                               pc:      bus.st_pc};
        end
    end

    // An entry is live when its distance from head is below the occupancy.
    for (genvar g = 0; g < DEPTH; g++) begin : g_valid
        logic [PTR_W-1:0] off;
        assign off      = PTR_W'(g) - head;
        assign valid[g] = ({1'b0, off} < count);
    end

    assign bus.dm_we    = drain;
    assign bus.dm_addr  = drain ? {entries[head].addr_hi, 2'b00} : '0;
    assign bus.dm_wdata = drain ? entries[head].data : '0;
    assign bus.dm_be    = drain ? entries[head].be : '0;
    assign bus.dm_pc    = drain ? entries[head].pc : '0;

    sb_fwd_merge #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fwd (
        .entries    (entries),
        .valid      (valid),
        .head       (head),
        .count      (count),
        .ld_valid   (bus.ld_valid),
        .ld_addr_hi (bus.ld_addr[31:2]),
        .fwd_mask   (bus.fwd_mask),
        .fwd_data   (bus.fwd_data)
    );

endmodule

// File: tb/tb_dm_store_buffer.sv
// Bench for dm_store_buffer: reference FIFO model with a DM-write scoreboard
// plus directed forwarding, full, reset and wrap scenarios.
module tb_dm_store_buffer;
  import mem_pkg::*;

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  // {addr[31:0], data[31:0], be[3:0], pc[31:0]}, oldest at index 0
  logic [99:0] exp_q[$];
  int          mcnt = 0;

  dm_store_buffer_if bus ();

  dm_store_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcnt = 0;
      exp_q.delete();
    end else begin
      logic m_enq, m_deq;
      m_enq = bus.st_valid && (mcnt < 4) && (bus.st_be != 4'b0000);
      m_deq = (mcnt != 0) && !bus.ld_valid;
      if (m_deq) void'(exp_q.pop_front());
      if (m_enq) exp_q.push_back({bus.st_addr & 32'hFFFF_FFFC, bus.st_data, bus.st_be, bus.st_pc});
      mcnt = mcnt + (m_enq ? 1 : 0) - (m_deq ? 1 : 0);
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      logic        e_we;
      logic [3:0]  e_mask;
      logic [31:0] e_data;
      e_we = (mcnt != 0) && !bus.ld_valid;
      check("dm_we", {31'b0, bus.dm_we}, {31'b0, e_we});
      check("st_ready", {31'b0, bus.st_ready}, {31'b0, (mcnt != 4)});
      check("empty", {31'b0, bus.empty}, {31'b0, (mcnt == 0)});
      if (bus.dm_we && e_we) begin
        check("dm_addr", bus.dm_addr, exp_q[0][99:68]);
        check("dm_wdata", bus.dm_wdata, exp_q[0][67:36]);
        check("dm_be", {28'b0, bus.dm_be}, {28'b0, exp_q[0][35:32]});
        check("dm_pc", bus.dm_pc, exp_q[0][31:0]);
      end else if (!bus.dm_we) begin
        check("dm_addr_idle", bus.dm_addr, 32'h0);
      end
      e_mask = '0;
      e_data = '0;
      if (bus.ld_valid) begin
        foreach (exp_q[i]) begin
          if (exp_q[i][99:70] == bus.ld_addr[31:2]) begin
            for (int b = 0; b < 4; b++) begin
              if (exp_q[i][32+b]) begin
                e_mask[b]        = 1'b1;
                e_data[8*b +: 8] = exp_q[i][36+8*b +: 8];
              end
            end
          end
        end
      end
      check("fwd_mask", {28'b0, bus.fwd_mask}, {28'b0, e_mask});
      check("fwd_data", bus.fwd_data, e_data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic [31:0] pc);
    logic acc;
    acc = 1'b0;
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
    bus.st_be    = be;
    bus.st_pc    = pc;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      acc = bus.st_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) check("st_timeout", 32'd0, 32'd1);
    bus.st_valid = 1'b0;
  endtask

  task automatic drain_all();
    bus.ld_valid = 1'b0;
    for (int n = 0; n < 50 && mcnt != 0; n++) idle(1);
    check("drained", {31'b0, bus.empty}, 32'd1);
  endtask

  logic [3:0] be_tab [8];

  // ---------------- stimulus ----------------
  initial begin
    be_tab[0] = BE_WORD;   be_tab[1] = BE_HALF_LO; be_tab[2] = BE_HALF_HI;
    be_tab[3] = BE_BYTE0;  be_tab[4] = BE_BYTE1;   be_tab[5] = BE_BYTE2;
    be_tab[6] = BE_BYTE3;  be_tab[7] = BE_NONE;

    bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0;
    bus.st_be = '0; bus.st_pc = '0; bus.ld_valid = 1'b0; bus.ld_addr = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_st_ready", {31'b0, bus.st_ready}, 32'd1);
    check("rst_empty", {31'b0, bus.empty}, 32'd1);
    check("rst_dm_we", {31'b0, bus.dm_we}, 32'd0);
    check("rst_fwd_mask", {28'b0, bus.fwd_mask}, 32'd0);
    check("rst_fwd_data", bus.fwd_data, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // 1: single store, drains the next cycle
    do_store(32'h10, 32'h1122_3344, BE_WORD, 32'h100);
    @(negedge clk);
    check("t1_we", {31'b0, bus.dm_we}, 32'd1);
    check("t1_addr", bus.dm_addr, 32'h10);
    check("t1_wdata", bus.dm_wdata, 32'h1122_3344);
    check("t1_be", {28'b0, bus.dm_be}, 32'hF);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_empty", {31'b0, bus.empty}, 32'd1);
    @(posedge clk); #1;

    // 2: fill under load pressure, then drain in order
    bus.ld_valid = 1'b1; bus.ld_addr = 32'h800;
    for (int i = 0; i < 4; i++) do_store(32'(4 * i), 32'hA000_0000 + 32'(i), BE_WORD, 32'h200 + 32'(4 * i));
    @(negedge clk);
    check("t2_full", {31'b0, bus.st_ready}, 32'd0);
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
    @(negedge clk);
    check("t2_first", bus.dm_addr, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t2_ready", {31'b0, bus.st_ready}, 32'd1);
    check("t2_second", bus.dm_addr, 32'h4);
    drain_all();

    // 3: word + byte overlay forwarding
    bus.ld_valid = 1'b1; bus.ld_addr = 32'h20;
    do_store(32'h20, 32'hAABB_CCDD, BE_WORD, 32'h300);
    do_store(32'h21, 32'h0000_EE00, BE_BYTE1, 32'h304);
    @(negedge clk);
    check("t3_mask", {28'b0, bus.fwd_mask}, 32'hF);
    check("t3_data", bus.fwd_data, 32'hAABB_EEDD);
    @(posedge clk); #1;
    drain_all();

    // 4: halfword forwarding, then a non-matching address
    bus.ld_valid = 1'b1; bus.ld_addr = 32'h30;
    do_store(32'h30, 32'h5566_0000, BE_HALF_HI, 32'h400);
    @(negedge clk);
    check("t4_mask", {28'b0, bus.fwd_mask}, 32'hC);
    check("t4_data", bus.fwd_data, 32'h5566_0000);
    @(posedge clk); #1;
    bus.ld_addr = 32'h34;
    @(negedge clk);
    check("t4_miss", {28'b0, bus.fwd_mask}, 32'h0);
    @(posedge clk); #1;
    drain_all();

    // 5: full buffer, drain and store in the same cycle
    bus.ld_valid = 1'b1;
    for (int i = 0; i < 4; i++) do_store(32'h50 + 32'(4 * i), $urandom, BE_WORD, 32'h500 + 32'(i));
    bus.ld_valid = 1'b0;
    bus.st_valid = 1'b1; bus.st_addr = 32'h60; bus.st_data = 32'hCAFE_F00D;
    bus.st_be = BE_WORD; bus.st_pc = 32'h510;
    @(negedge clk);
    check("t5_refused", {31'b0, bus.st_ready}, 32'd0);
    check("t5_drain", {31'b0, bus.dm_we}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_ready", {31'b0, bus.st_ready}, 32'd1);
    @(posedge clk); #1;
    bus.st_valid = 1'b0;
    drain_all();

    // 6a: asynchronous reset with three entries pending
    bus.ld_valid = 1'b1;
    for (int i = 0; i < 3; i++) do_store(32'h70 + 32'(4 * i), $urandom, BE_WORD, 32'h600 + 32'(i));
    bus.ld_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("t6_rst_we", {31'b0, bus.dm_we}, 32'd0);
    check("t6_rst_empty", {31'b0, bus.empty}, 32'd1);
    check("t6_rst_ready", {31'b0, bus.st_ready}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(4);

    // 6b: wrap-around, ten back-to-back stores
    for (int i = 0; i < 10; i++) do_store(32'h90 + 32'(4 * i), $urandom, be_tab[i % 7], 32'h700 + 32'(i));
    drain_all();

    // random traffic; the model and scoreboard check every cycle
    for (int c = 0; c < 300; c++) begin
      bus.st_valid = ($urandom_range(0, 1) == 1);
      bus.st_addr  = 32'h40 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
      bus.st_data  = $urandom;
      bus.st_be    = be_tab[$urandom_range(0, 7)];
      bus.st_pc    = 32'h1000 + 32'(c * 4);
      bus.ld_valid = ($urandom_range(0, 2) == 0);
      bus.ld_addr  = 32'h40 + 32'($urandom_range(0, 4) * 4);
      idle(1);
    end
    bus.st_valid = 1'b0;
    drain_all();
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_store_buffer.md
Name: dm_store_buffer

Overview:
- Posted-write buffer sitting directly upstream of the data memory in the M stage.
- Accepts stores from the pipeline and queues up to DEPTH entries in order.
- Drains one entry per cycle into the DM write port whenever the DM port is not claimed by a load.
- Forwards pending store bytes to same-cycle loads so loads never read stale DM contents.

Parameters:
- DEPTH, 4: number of buffered stores; power of two, at least 2.
- PTR_W, $clog2(DEPTH): pointer index width. The occupancy counter is PTR_W+1 bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- st_valid  input  1  M-stage store request.
- st_addr  input  32  store byte address; bits [1:0] are ignored and lane selection comes from st_be.
- st_data  input  32  store data, already lane-aligned.
- st_be  input  4  byte enables: sw=1111, sh=0011/1100, sb=one-hot.
- st_pc  input  32  PC of the store, carried for the DM write trace.
- st_ready  output  1  buffer can accept a store this cycle.
- ld_valid  input  1  M-stage load; claims the DM port this cycle.
- ld_addr  input  32  load byte address.
- fwd_mask  output  4  per-byte: 1 = byte supplied by the buffer.
- fwd_data  output  32  forwarded bytes; lanes with mask 0 are 0.
- dm_we  output  1  DM write strobe.
- dm_addr  output  32  DM write address = {entry addr[31:2], 2'b00}.
- dm_wdata  output  32  DM write data.
- dm_be  output  4  DM byte enables.
- dm_pc  output  32  PC of the draining store.
- empty  output  1  no pending stores; used for sync/halt.

Behaviour:
- Storage and pointers
  - Circular array of DEPTH entries, each {addr[31:2], data, be, pc}.
  - head, tail and count registers.
  - full = (count == DEPTH); empty = (count == 0).
- Reset (reset==0, asynchronous)
  - head=tail=count=0; all pending stores are discarded, including a reset mid-drain.
  - Outputs during and after reset: st_ready=1, empty=1, dm_we=0, fwd_mask=0, fwd_data=0.
  - dm_addr/dm_wdata/dm_be/dm_pc are 0 while dm_we=0.
- Enqueue
  - st_ready = !full, independent of the same-cycle drain.
  - On st_valid && st_ready: write the entry at tail, tail+1 (wraps modulo DEPTH), count+1.
  - st_valid with st_be==0000 is accepted as a no-op: not enqueued, count unchanged.
- Drain
  - dm_we = !empty && !ld_valid, combinational from the head entry.
  - On dm_we, at the clock edge: head+1 (wraps), count-1.
  - Minimum latency: a store accepted in cycle N can drain in cycle N+1.
  - A store arriving into an empty buffer is never bypassed straight to DM in the same cycle.
- Simultaneous enqueue and drain: count unchanged, both pointers advance.
- When full, enqueue is refused even if a drain happens that cycle. The pipeline stalls on !st_ready.
- Loads always win the DM port. Sustained ld_valid starves the drain; no fairness is required.
- Forwarding (combinational)
  - Candidates: valid entries with addr[31:2] == ld_addr[31:2].
  - For each byte lane, the youngest matching entry with that be bit set supplies the byte and sets the fwd_mask bit.
  - The head entry is a candidate even while it drains this cycle (a drain only happens with ld_valid=0, so this is consistent).
  - The store being enqueued this cycle is NOT forwarded; hazard logic already orders store→load in program order across stages.
  - fwd_mask=0 when ld_valid=0.
- Ordering: DM sees writes in exact program order. No coalescing, no reordering.

Decomposition:
- Shared package (mem_pkg):
  - byte-enable constants BE_WORD=4'b1111, BE_HALF_LO/HI, BE_BYTE0..3;
  - entry struct typedef {addr_hi, data, be, pc};
  - DEPTH default.
- Sub-module sb_fwd_merge: takes the entry array, a valid vector, head, count and ld_addr, and produces fwd_mask/fwd_data using per-lane youngest-first priority.
- The FIFO control stays in the top module.

Test Plan:
1. Reset, then st_valid with st_addr=0x0000_0010, st_data=0x1122_3344, st_be=1111, ld_valid=0 → next cycle: dm_we=1, dm_addr=0x10, dm_wdata=0x11223344, dm_be=1111; the following cycle empty=1.
2. Four stores to 0x0, 0x4, 0x8, 0xC with ld_valid=1 held high → st_ready=0 after the 4th; then drop ld_valid → drains over 4 cycles in order 0x0, 0x4, 0x8, 0xC; st_ready=1 after the first drain.
3. Two buffered stores: sw 0x20 ← 0xAABBCCDD, then sb 0x21 ← 0x0000_EE00 (be=0010), load 0x20 held → fwd_mask=1111, fwd_data=0xAABBEEDD.
4. Buffered sh to 0x30 (be=1100, data=0x5566_0000), load 0x30 → fwd_mask=1100, fwd_data=0x55660000. Load 0x34 → fwd_mask=0000.
5. Full buffer with a drain in the same cycle as a st_valid → st_ready=0 and the store is not taken; count goes 4→3; the store is accepted on the next cycle.
6. Assert reset=0 asynchronously mid-cycle with 3 entries pending → dm_we=0 and empty=1 immediately, with no DM write after release; a wrap-around check cycles 10 stores through DEPTH=4 with correct order.
